hazard_ctrl_unit: RTL and testbench
===================================

// Module: hazard_ctrl_unit
// PURPOSE
//   Pipeline sequencing controller for the IF stage and IF/ID, ID/EX registers.
//   Generates the PC write enable, IF/ID write enable, IF/ID flush and ID/EX bubble.
//   Sources: load-use hazards, taken branches resolved in EX, data-memory wait
//   states and a HALT instruction decoded in ID.
//   Also keeps saturating stall and flush performance counters.
// PARAMETERS
//   REG_W        5   register-address width (Rs/Rt/Rd)
//   FLUSH_CYCLES 1   cycles of IF/ID flush per taken branch (1..15)
//   CNT_W        16  width of the stall and flush performance counters
// PORTS
//   clk              in   1      pipeline clock (same clock as IF_STAGE clk)
//   rst              in   1      asynchronous reset, active-high
//   ID_Rs            in   REG_W  source register 1 of the instruction in ID
//   ID_Rt            in   REG_W  source register 2 of the instruction in ID
//   EX_MemRead       in   1      instruction in EX is a load
//   EX_RegRd         in   REG_W  destination register of the instruction in EX
//   BranchTaken      in   1      branch resolved taken in EX (same net as IF_STAGE)
//   DM_Busy          in   1      data memory is inserting a wait state
//   Halt_Req         in   1      HALT opcode decoded in ID
//   PC_WriteEnable   out  1      PC register load enable
//   IF_ID_WriteEnable out 1      IF/ID register load enable
//   IF_ID_Flush      out  1      IF/ID register clears to NOP on the next edge
//   ID_EX_Bubble     out  1      ID/EX loads NOP control on the next edge
//   Halted           out  1      core halted
//   StallCount       out  CNT_W  load-use plus DM_Busy stall cycles (saturating)
//   FlushCount       out  CNT_W  flush cycles issued (saturating)
// BEHAVIOUR
//   FSM states: RUN, FLUSH, HALT.
//   Counters are registered; outputs decode combinationally from state, inputs and flush_left.
//   While rst=1, state is RUN, flush_left=0 and both counters are 0. All 1-bit outputs are 0.
//   LoadUse = EX_MemRead & (EX_RegRd!=0) & (EX_RegRd==ID_Rs | EX_RegRd==ID_Rt).
//   RUN priority (highest first):
//     DM_Busy:     Freeze. PC_WE=0, IF_ID_WE=0, Flush=0, Bubble=0; StallCount+1; stay RUN.
//     BranchTaken: PC_WE=1 (IF selects BranchTarget), IF_ID_WE=1, Flush=1, Bubble=1;
//                  FlushCount+1. If FLUSH_CYCLES>1: flush_left<=FLUSH_CYCLES-1, go FLUSH.
//                  Otherwise stay RUN. A Halt_Req in the same cycle is squashed.
//     LoadUse:     PC_WE=0, IF_ID_WE=0, Flush=0, Bubble=1; StallCount+1.
//                  Single cycle; the re-check next cycle clears naturally.
//     Halt_Req:    PC_WE=0, IF_ID_WE=0, Bubble=1; go HALT.
//     else:        PC_WE=1, IF_ID_WE=1, Flush=0, Bubble=0.
//   FLUSH:
//     DM_Busy:  Freeze as in RUN; flush_left holds; StallCount+1.
//     Otherwise: PC_WE=1, IF_ID_WE=1, Flush=1, Bubble=1; FlushCount+1; flush_left-1.
//                Return to RUN when flush_left==1. BranchTaken, LoadUse and Halt_Req are ignored.
//   HALT: PC_WE=0, IF_ID_WE=0, Flush=0, Bubble=1, Halted=1. Only rst exits HALT.
//   Counters saturate at all-ones and never wrap.
//   Reset asserted mid-FLUSH or in HALT returns to RUN; counters clear immediately.
//   Latency: every control decision applies to the edge ending the current cycle; no extra pipeline delay.
// TESTING
//   1. rst=1 then released:
//      during rst all outputs are 0; first RUN cycle gives PC_WE=1, IF_ID_WE=1; counters are 0.
//   2. EX_MemRead=1, EX_RegRd=5, ID_Rs=5 for one cycle:
//      PC_WE=0, IF_ID_WE=0, Bubble=1; StallCount=1. Repeat with EX_RegRd=0: no stall.
//   3. FLUSH_CYCLES=2, BranchTaken=1 for one cycle:
//      Flush=1 and Bubble=1 for 2 consecutive cycles; FlushCount=2; back to RUN.
//   4. BranchTaken=1, LoadUse and Halt_Req all in the same cycle:
//      branch path only; no HALT; StallCount unchanged.
//   5. FLUSH_CYCLES=3, DM_Busy=1 for 3 cycles starting mid-FLUSH:
//      all enables 0 for 3 cycles; StallCount+3; flush then resumes for the remaining cycles.
//   6. Halt_Req=1 -> Halted=1, PC_WE=0 held for 10 cycles; rst pulse -> Halted=0, RUN.
//      Preload StallCount to all-ones via a long DM_Busy run (CNT_W=4): it holds at 15.

Source files
------------

// File: rtl/hazard_ctrl_unit.sv
// hazard_ctrl_unit: pipeline sequencing controller for IF, IF/ID and ID/EX.
// Resolves data-memory wait states, taken branches, load-use hazards and HALT
// into PC / IF/ID enables, an IF/ID flush and an ID/EX bubble, and keeps
// saturating stall and flush cycle counters.
module hazard_ctrl_unit #(
  parameter int REG_W        = 5,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] ID_Rs,
  input  logic [REG_W-1:0] ID_Rt,
  input  logic             EX_MemRead,
  input  logic [REG_W-1:0] EX_RegRd,
  input  logic             BranchTaken,
  input  logic             DM_Busy,
  input  logic             Halt_Req,
  output logic             PC_WriteEnable,
  output logic             IF_ID_WriteEnable,
  output logic             IF_ID_Flush,
  output logic             ID_EX_Bubble,
  output logic             Halted,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] FlushCount
);

  typedef enum logic [1:0] {RUN, FLUSH, HALT} state_t;

  // Remaining flush cycles loaded when a branch opens a multi-cycle flush window.
  localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES - 1);

  state_t     state;
  logic [3:0] flush_left;
  logic       load_use;
  logic       stall_inc;
  logic       flush_inc;

  assign load_use = EX_MemRead && (EX_RegRd != '0) &&
                    ((EX_RegRd == ID_Rs) || (EX_RegRd == ID_Rt));

  // Decode the control outputs for the current cycle; everything is forced low while in reset.
  always_comb begin
    PC_WriteEnable    = 1'b0;
    IF_ID_WriteEnable = 1'b0;
    IF_ID_Flush       = 1'b0;
    ID_EX_Bubble      = 1'b0;
    Halted            = 1'b0;
    stall_inc         = 1'b0;
    flush_inc         = 1'b0;
    if (!rst) begin
      unique case (state)
        RUN: begin
          if (DM_Busy) begin
            stall_inc = 1'b1;
          end else if (BranchTaken) begin
            PC_WriteEnable    = 1'b1;
            IF_ID_WriteEnable = 1'b1;
            IF_ID_Flush       = 1'b1;
            ID_EX_Bubble      = 1'b1;
            flush_inc         = 1'b1;
          end else if (load_use) begin
            ID_EX_Bubble = 1'b1;
            stall_inc    = 1'b1;
          end else if (Halt_Req) begin
            ID_EX_Bubble = 1'b1;
          end else begin
            PC_WriteEnable    = 1'b1;
            IF_ID_WriteEnable = 1'b1;
          end
        end
        FLUSH: begin
          if (DM_Busy) begin
            stall_inc = 1'b1;
          end else begin
            PC_WriteEnable    = 1'b1;
            IF_ID_WriteEnable = 1'b1;
            IF_ID_Flush       = 1'b1;
            ID_EX_Bubble      = 1'b1;
            flush_inc         = 1'b1;
          end
        end
        HALT: begin
          ID_EX_Bubble = 1'b1;
          Halted       = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Sequencer state and flush countdown; a frozen (DM_Busy) cycle leaves both untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= RUN;
      flush_left <= 4'd0;
    end else begin
      unique case (state)
        RUN: begin
          if (!DM_Busy) begin
            if (BranchTaken) begin
              if (FLUSH_CYCLES > 1) begin
                state      <= FLUSH;
                flush_left <= FLUSH_INIT;
              end
            end else if (!load_use && Halt_Req) begin
              state <= HALT;
            end
          end
        end
        FLUSH: begin
          if (!DM_Busy) begin
            flush_left <= flush_left - 4'd1;
            if (flush_left == 4'd1) begin
              state <= RUN;
            end
          end
        end
        HALT: state <= HALT;
        default: state <= RUN;
      endcase
    end
  end

  // Saturating performance counters; they stick at all-ones instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      StallCount <= '0;
      FlushCount <= '0;
    end else begin
      if (stall_inc && (StallCount != '1)) begin
        StallCount <= StallCount + CNT_W'(1);
      end
      if (flush_inc && (FlushCount != '1)) begin
        FlushCount <= FlushCount + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// tb_hazard_ctrl_unit: two controller instances (2-cycle flush with wide
// counters, 3-cycle flush with 4-bit counters) driven by the same inputs and
// compared each cycle against queued expectations from a reference model.
module tb_hazard_ctrl_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs, id_rt, ex_rd;
  logic       ex_memread, branch_taken, dm_busy, halt_req;

  logic        a_pc, a_ifid, a_flush, a_bubble, a_halted;
  logic [15:0] a_stall, a_fcnt;
  logic        b_pc, b_ifid, b_flush, b_bubble, b_halted;
  logic [3:0]  b_stall, b_fcnt;

  typedef struct packed {
    logic [4:0]  ctl;
    logic [15:0] stall;
    logic [15:0] fcnt;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  int errors = 0;
  int checks = 0;

  // Reference model state, one slot per instance.
  int mState[2];
  int mLeft[2];
  int mStall[2];
  int mFcnt[2];
  int fcCfg[2]  = '{2, 3};
  int maxCfg[2] = '{65535, 15};

  hazard_ctrl_unit #(.REG_W(5), .FLUSH_CYCLES(2), .CNT_W(16)) dutA (
    .clk(clk), .rst(rst), .ID_Rs(id_rs), .ID_Rt(id_rt),
    .EX_MemRead(ex_memread), .EX_RegRd(ex_rd), .BranchTaken(branch_taken),
    .DM_Busy(dm_busy), .Halt_Req(halt_req),
    .PC_WriteEnable(a_pc), .IF_ID_WriteEnable(a_ifid), .IF_ID_Flush(a_flush),
    .ID_EX_Bubble(a_bubble), .Halted(a_halted),
    .StallCount(a_stall), .FlushCount(a_fcnt)
  );

  hazard_ctrl_unit #(.REG_W(5), .FLUSH_CYCLES(3), .CNT_W(4)) dutB (
    .clk(clk), .rst(rst), .ID_Rs(id_rs), .ID_Rt(id_rt),
    .EX_MemRead(ex_memread), .EX_RegRd(ex_rd), .BranchTaken(branch_taken),
    .DM_Busy(dm_busy), .Halt_Req(halt_req),
    .PC_WriteEnable(b_pc), .IF_ID_WriteEnable(b_ifid), .IF_ID_Flush(b_flush),
    .ID_EX_Bubble(b_bubble), .Halted(b_halted),
    .StallCount(b_stall), .FlushCount(b_fcnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Expected outputs for the current cycle of instance k, then advance the model.
  task automatic modelStep(input int k, output exp_t e);
    logic lu;
    logic [4:0] ctl;
    lu = ex_memread && (ex_rd != 5'd0) && ((ex_rd == id_rs) || (ex_rd == id_rt));
    ctl = 5'b00000;
    if (rst) begin
      mState[k] = 0; mLeft[k] = 0; mStall[k] = 0; mFcnt[k] = 0;
      e = '0;
      return;
    end
    e.stall = 16'(mStall[k]);
    e.fcnt  = 16'(mFcnt[k]);
    if (mState[k] == 2) begin
      ctl = 5'b00011;
    end else if (dm_busy) begin
      ctl = 5'b00000;
      if (mStall[k] < maxCfg[k]) mStall[k]++;
    end else if (mState[k] == 1) begin
      ctl = 5'b11110;
      if (mFcnt[k] < maxCfg[k]) mFcnt[k]++;
      if (mLeft[k] == 1) mState[k] = 0;
      mLeft[k]--;
    end else if (branch_taken) begin
      ctl = 5'b11110;
      if (mFcnt[k] < maxCfg[k]) mFcnt[k]++;
      if (fcCfg[k] > 1) begin
        mState[k] = 1;
        mLeft[k]  = fcCfg[k] - 1;
      end
    end else if (lu) begin
      ctl = 5'b00010;
      if (mStall[k] < maxCfg[k]) mStall[k]++;
    end else if (halt_req) begin
      ctl = 5'b00010;
      mState[k] = 2;
    end else begin
      ctl = 5'b11000;
    end
    e.ctl = ctl;
  endtask

  // Drive one cycle of inputs just after the rising edge and queue the expectations.
  task automatic applyStimulus(input logic r, input logic mr, input logic [4:0] rd,
                               input logic [4:0] rs, input logic [4:0] rt,
                               input logic br, input logic busy, input logic hlt);
    exp_t ea, eb;
    @(posedge clk);
    #1;
    rst = r; ex_memread = mr; ex_rd = rd; id_rs = rs; id_rt = rt;
    branch_taken = br; dm_busy = busy; halt_req = hlt;
    modelStep(0, ea);
    modelStep(1, eb);
    qa.push_back(ea);
    qb.push_back(eb);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Compare the DUT outputs against the oldest queued expectation on every falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (qa.size() > 0) begin
      e = qa.pop_front();
      checkOutput("A.ctl",   {27'd0, a_pc, a_ifid, a_flush, a_bubble, a_halted}, {27'd0, e.ctl});
      checkOutput("A.stall", {16'd0, a_stall}, {16'd0, e.stall});
      checkOutput("A.flush", {16'd0, a_fcnt},  {16'd0, e.fcnt});
    end
    if (qb.size() > 0) begin
      e = qb.pop_front();
      checkOutput("B.ctl",   {27'd0, b_pc, b_ifid, b_flush, b_bubble, b_halted}, {27'd0, e.ctl});
      checkOutput("B.stall", {28'd0, b_stall}, {16'd0, e.stall});
      checkOutput("B.flush", {28'd0, b_fcnt},  {16'd0, e.fcnt});
    end
  end

  initial begin
    rst = 1'b1; ex_memread = 0; ex_rd = 0; id_rs = 0; id_rt = 0;
    branch_taken = 0; dm_busy = 0; halt_req = 0;

    // Reset, then plain running
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    idle(2);

    // Load-use on Rs, on Rt, then a load into r0 which must not stall
    applyStimulus(0, 1, 5'd5, 5'd5, 5'd1, 0, 0, 0);
    idle(1);
    applyStimulus(0, 1, 5'd7, 5'd2, 5'd7, 0, 0, 0);
    applyStimulus(0, 1, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    applyStimulus(0, 0, 5'd5, 5'd5, 5'd5, 0, 0, 0);
    idle(1);

    // Single taken branch
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 0);
    idle(4);

    // Branch together with load-use and halt: branch wins, no halt
    applyStimulus(0, 1, 5'd3, 5'd3, 5'd0, 1, 0, 1);
    idle(4);

    // Data-memory wait states landing inside a flush window
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 0);
    idle(1);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);
    idle(4);

    // Halt holds regardless of inputs until reset
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 10; i++) applyStimulus(0, 0, 0, 0, 0, i[0], i[1], 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    idle(2);

    // Long wait-state run saturates the 4-bit stall counter
    for (int i = 0; i < 20; i++) applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);
    idle(2);
    applyStimulus(0, 1, 5'd4, 5'd4, 5'd0, 0, 0, 0);
    idle(1);

    // Random traffic
    for (int i = 0; i < 80; i++) begin
      applyStimulus(0, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                    5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                    ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0),
                    ($urandom_range(0, 24) == 0));
    end
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    idle(2);

    @(negedge clk);
    #1;
    checkOutput("qa.drain", 32'(qa.size()), 32'd0);
    checkOutput("qb.drain", 32'(qb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
